// File: rtl/tetron_collision_if.sv
// Bundle between the checker, the piece-movement controller and the board RAM
// read port.
//
// Handshake: start is a request level that the checker samples only while
// idle; once it is taken, busy rises on the next cycle and start is ignored.
// done is a one-cycle pulse, and collision/out_of_bounds are valid from that
// cycle until the next accepted start. The board RAM answers every cycle in
// which board_rd_en is high with board_rd_data on the following cycle.
// board_rd_addr is meaningful only while board_rd_en is high; otherwise it
// holds the last address read.
interface tetron_collision_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [4:0]        anchor_row;
  logic [4:0]        anchor_col;
  logic [4:0]        blk1_voffset;
  logic [4:0]        blk2_voffset;
  logic [4:0]        blk3_voffset;
  logic [4:0]        blk4_voffset;
  logic [4:0]        blk1_hoffset;
  logic [4:0]        blk2_hoffset;
  logic [4:0]        blk3_hoffset;
  logic [4:0]        blk4_hoffset;
  logic              board_rd_en;
  logic [ADDR_W-1:0] board_rd_addr;
  logic              board_rd_data;
  logic              busy;
  logic              done;
  logic              collision;
  logic              out_of_bounds;

  // Environment side: the movement controller plus the board RAM.
  modport master (
    output start, anchor_row, anchor_col,
           blk1_voffset, blk2_voffset, blk3_voffset, blk4_voffset,
           blk1_hoffset, blk2_hoffset, blk3_hoffset, blk4_hoffset,
           board_rd_data,
    input  board_rd_en, board_rd_addr, busy, done, collision, out_of_bounds
  );

  // Checker side.
  modport slave (
    input  start, anchor_row, anchor_col,
           blk1_voffset, blk2_voffset, blk3_voffset, blk4_voffset,
           blk1_hoffset, blk2_hoffset, blk3_hoffset, blk4_hoffset,
           board_rd_data,
    output board_rd_en, board_rd_addr, busy, done, collision, out_of_bounds
  );
endinterface

// File: rtl/tetron_collision_checker.sv
// Walks the four blocks of a candidate tetron placement in order 1..4.
// Each block is bounds-checked and then looked up in the board RAM. The walk
// stops at the first block that is off the board or lands on an occupied
// cell.
module tetron_collision_checker #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int ADDR_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  tetron_collision_if.slave   bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK, DONE} state_t;

  state_t            state_q, state_d;
  logic [4:0]        anchor_row_q, anchor_col_q;
  logic [4:0]        voff_q [4];
  logic [4:0]        hoff_q [4];
  logic [1:0]        idx_q;
  logic              coll_q, oob_q;
  logic [ADDR_W-1:0] addr_q;

  logic [6:0]        cell_row, cell_col;
  logic              cell_oob;
  logic [ADDR_W-1:0] cell_addr;
  logic              accept, rd_fire, hit;

  // Cell of the current block in 7-bit signed space; bit 6 set means negative.
  always_comb begin
    cell_row  = {2'b00, anchor_row_q} + {{2{voff_q[idx_q][4]}}, voff_q[idx_q]};
    cell_col  = {2'b00, anchor_col_q} + {{2{hoff_q[idx_q][4]}}, hoff_q[idx_q]};
    cell_oob  = cell_row[6] | cell_col[6] |
                (cell_row >= 7'(BOARD_H)) | (cell_col >= 7'(BOARD_W));
    cell_addr = ADDR_W'(cell_row) * ADDR_W'(BOARD_W) + ADDR_W'(cell_col);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and the per-state strobes that drive the datapath.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    rd_fire = 1'b0;
    hit     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cell_oob) begin
          state_d = DONE;
        end else begin
          rd_fire = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (bus.board_rd_data) begin
          hit     = 1'b1;
          state_d = DONE;
        end else if (idx_q == 2'd3) begin
          state_d = DONE;
        end else begin
          state_d = ISSUE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, block index, sticky verdict and last read address.
  always_ff @(posedge clk) begin
    if (rst) begin
      anchor_row_q <= '0;
      anchor_col_q <= '0;
      for (int i = 0; i < 4; i++) begin
        voff_q[i] <= '0;
        hoff_q[i] <= '0;
      end
      idx_q  <= '0;
      coll_q <= 1'b0;
      oob_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      if (accept) begin
        anchor_row_q <= bus.anchor_row;
        anchor_col_q <= bus.anchor_col;
        voff_q[0]    <= bus.blk1_voffset;
        voff_q[1]    <= bus.blk2_voffset;
        voff_q[2]    <= bus.blk3_voffset;
        voff_q[3]    <= bus.blk4_voffset;
        hoff_q[0]    <= bus.blk1_hoffset;
        hoff_q[1]    <= bus.blk2_hoffset;
        hoff_q[2]    <= bus.blk3_hoffset;
        hoff_q[3]    <= bus.blk4_hoffset;
        idx_q        <= '0;
        coll_q       <= 1'b0;
        oob_q        <= 1'b0;
      end
      if (state_q == ISSUE && cell_oob) begin
        oob_q  <= 1'b1;
        coll_q <= 1'b1;
      end
      if (rd_fire) addr_q <= cell_addr;
      if (hit) coll_q <= 1'b1;
      if (state_q == CHECK && !bus.board_rd_data && idx_q != 2'd3)
        idx_q <= idx_q + 2'd1;
    end
  end

  // Outputs: the read strobe and address come straight from ISSUE so the read
  // lands in the same cycle the cell is computed.
  always_comb begin
    bus.board_rd_en   = rd_fire;
    bus.board_rd_addr = rd_fire ? cell_addr : addr_q;
    bus.busy          = (state_q == ISSUE) || (state_q == CHECK);
    bus.done          = (state_q == DONE);
    bus.collision     = coll_q;
    bus.out_of_bounds = oob_q;
    dbg_state         = state_q;
  end

endmodule

// File: tb/tb_tetron_collision_checker.sv
// Bench for tetron_collision_checker: directed placements with literal
// expectations, followed by randomized placements on random boards.
module tb_tetron_collision_checker;
  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;
  localparam int ADDR_W  = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  tetron_collision_if #(.ADDR_W(ADDR_W)) bus();

  tetron_collision_checker #(
    .BOARD_W(BOARD_W), .BOARD_H(BOARD_H), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Board RAM: one-cycle read latency.
  bit board [256];
  always @(posedge clk) bus.board_rd_data <= bus.board_rd_en ? board[bus.board_rd_addr] : 1'b0;

  // ---------------- scoreboard ----------------
  // kind 0: idle cycle (sticky verdict), 1: explicit cycle, 2: first cycle after reset
  typedef struct {
    int kind; bit en; int addr; bit busy; bit done; bit coll; bit oob;
  } exp_t;
  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  bit st_coll  = 1'b0;
  bit st_oob   = 1'b0;
  int last_addr = 0;
  bit cmp_on   = 1'b0;
  int rd_addr_log[$];
  int rd_cyc_log[$];
  int done_cyc  = -1;
  int start_cyc = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison of every output against the model's schedule.
  always @(negedge clk) begin : cmp_proc
    exp_t e;
    if (cmp_on) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = '{0, 0, 0, 0, 0, 0, 0};
      if (e.kind == 2) begin
        st_coll = 1'b0; st_oob = 1'b0; last_addr = 0;
      end
      if (e.kind != 1) begin
        e.en = 0; e.busy = 0; e.done = 0; e.coll = st_coll; e.oob = st_oob;
      end
      chk("rd_en",         bus.board_rd_en, e.en);
      chk("rd_addr",       bus.board_rd_addr, e.en ? e.addr : last_addr);
      chk("busy",          bus.busy, e.busy);
      chk("done",          bus.done, e.done);
      chk("collision",     bus.collision, e.coll);
      chk("out_of_bounds", bus.out_of_bounds, e.oob);
      if (e.kind == 1 && e.en) last_addr = e.addr;
      if (e.kind == 1 && e.done) begin
        st_coll = e.coll; st_oob = e.oob;
      end
      if (bus.board_rd_en) begin
        rd_addr_log.push_back(int'(bus.board_rd_addr));
        rd_cyc_log.push_back(cyc);
      end
      if (bus.done) done_cyc = cyc;
    end
  end

  // ---------------- behavioural model ----------------
  // Walk the blocks in order; an in-bounds block costs a read cycle and a
  // check cycle, an off-board block costs one cycle, then one done cycle.
  task automatic model_push(int ar, int ac, int v[4], int h[4]);
    int r, c, a;
    bit stop, coll, oob;
    stop = 0; coll = 0; oob = 0;
    exp_q.push_back('{0, 0, 0, 0, 0, 0, 0});
    for (int k = 0; k < 4; k++) begin
      if (!stop) begin
        r = ar + v[k];
        c = ac + h[k];
        if (r < 0 || r >= BOARD_H || c < 0 || c >= BOARD_W) begin
          exp_q.push_back('{1, 0, 0, 1, 0, 0, 0});
          oob = 1; coll = 1; stop = 1;
        end else begin
          a = r * BOARD_W + c;
          exp_q.push_back('{1, 1, a, 1, 0, 0, 0});
          exp_q.push_back('{1, 0, 0, 1, 0, 0, 0});
          if (board[a]) begin
            coll = 1; stop = 1;
          end
        end
      end
    end
    exp_q.push_back('{1, 0, 0, 0, 1, coll, oob});
  endtask

  // ---------------- driver tasks ----------------
  task automatic scramble_inputs();
    bus.anchor_row   = 5'($urandom); bus.anchor_col   = 5'($urandom);
    bus.blk1_voffset = 5'($urandom); bus.blk2_voffset = 5'($urandom);
    bus.blk3_voffset = 5'($urandom); bus.blk4_voffset = 5'($urandom);
    bus.blk1_hoffset = 5'($urandom); bus.blk2_hoffset = 5'($urandom);
    bus.blk3_hoffset = 5'($urandom); bus.blk4_hoffset = 5'($urandom);
  endtask

  task automatic do_start(int ar, int ac, int v[4], int h[4]);
    @(posedge clk); #1;
    bus.anchor_row   = 5'(ar);   bus.anchor_col   = 5'(ac);
    bus.blk1_voffset = 5'(v[0]); bus.blk2_voffset = 5'(v[1]);
    bus.blk3_voffset = 5'(v[2]); bus.blk4_voffset = 5'(v[3]);
    bus.blk1_hoffset = 5'(h[0]); bus.blk2_hoffset = 5'(h[1]);
    bus.blk3_hoffset = 5'(h[2]); bus.blk4_hoffset = 5'(h[3]);
    bus.start = 1'b1;
    if (exp_q.size() == 0) begin
      model_push(ar, ac, v, h);
      start_cyc = cyc;
      rd_addr_log.delete();
      rd_cyc_log.delete();
      done_cyc = -1;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    scramble_inputs();
  endtask

  task automatic pulse_rst();
    exp_t tmp;
    @(posedge clk); #1;
    rst = 1'b1;
    if (exp_q.size() == 0) begin
      exp_q.push_back('{0, 0, 0, 0, 0, 0, 0});
    end else begin
      tmp = exp_q[0];
      exp_q.delete();
      exp_q.push_back(tmp);
    end
    exp_q.push_back('{2, 0, 0, 0, 0, 0, 0});
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Literal expectations for the most recently accepted request.
  task automatic check_result(string tag, int n, int a[4], int lat, bit coll, bit oob);
    chk({tag, "_nreads"}, rd_addr_log.size(), n);
    for (int i = 0; i < n && i < rd_addr_log.size(); i++) begin
      chk({tag, "_addr"}, rd_addr_log[i], a[i]);
      chk({tag, "_rdcyc"}, rd_cyc_log[i] - start_cyc, 2 * i + 1);
    end
    chk({tag, "_latency"}, done_cyc - start_cyc, lat);
    chk({tag, "_collision"}, bus.collision, coll);
    chk({tag, "_oob"}, bus.out_of_bounds, oob);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int v[4], h[4], v2[4], h2[4];
    int ar, ac, r;
    bus.start = 1'b0;
    scramble_inputs();
    for (int i = 0; i < 256; i++) board[i] = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rd_en",     bus.board_rd_en, 1'b0);
    chk("reset_rd_addr",   bus.board_rd_addr, 0);
    chk("reset_busy",      bus.busy, 1'b0);
    chk("reset_done",      bus.done, 1'b0);
    chk("reset_collision", bus.collision, 1'b0);
    chk("reset_oob",       bus.out_of_bounds, 1'b0);
    chk("reset_state",     dbg_state, 2'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cmp_on = 1'b1;

    v = '{0, 0, 0, 1};
    h = '{0, 1, -1, 0};

    // Clean placement on an empty board.
    do_start(5, 4, v, h);
    wait_cycles(12);
    check_result("clean", 4, '{54, 55, 53, 64}, 9, 0, 0);

    // Second block hits an occupied cell.
    board[55] = 1'b1;
    do_start(5, 4, v, h);
    wait_cycles(12);
    check_result("hit2", 2, '{54, 55, 0, 0}, 5, 1, 0);
    board[55] = 1'b0;

    // Third block falls off the left edge.
    do_start(5, 0, v, h);
    wait_cycles(12);
    check_result("oob_left", 2, '{50, 51, 0, 0}, 6, 1, 1);

    // Fourth block falls below the bottom row.
    do_start(19, 4, v, h);
    wait_cycles(12);
    check_result("oob_bottom", 3, '{194, 195, 193, 0}, 8, 1, 1);

    // A second start at N+3 is ignored; a later one is accepted.
    v2 = '{0, 1, 1, 0};
    h2 = '{0, 0, 1, 1};
    do_start(5, 4, v, h);
    wait_cycles(1);
    do_start(2, 2, v2, h2);
    wait_cycles(12);
    check_result("ignored_start", 4, '{54, 55, 53, 64}, 9, 0, 0);
    do_start(3, 3, v2, h2);
    wait_cycles(12);
    check_result("later_start", 4, '{33, 43, 44, 34}, 9, 0, 0);

    // Reset in the middle of a check aborts with no done pulse.
    do_start(5, 4, v, h);
    wait_cycles(2);
    pulse_rst();
    wait_cycles(6);
    chk("abort_no_done", done_cyc, -1);
    do_start(5, 4, v, h);
    wait_cycles(12);
    check_result("after_abort", 4, '{54, 55, 53, 64}, 9, 0, 0);

    // Randomized placements, boards, overlapping starts and aborts.
    for (int it = 0; it < 120; it++) begin
      for (int a = 0; a < 200; a++) board[a] = ($urandom_range(0, 9) == 0);
      ar = int'($urandom_range(0, 23));
      ac = int'($urandom_range(0, 13));
      if ($urandom_range(0, 19) == 0) ar = 31;
      for (int k = 0; k < 4; k++) begin
        v[k] = int'($urandom_range(0, 4)) - 2;
        h[k] = int'($urandom_range(0, 4)) - 2;
      end
      do_start(ar, ac, v, h);
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        wait_cycles(int'($urandom_range(0, 6)));
        pulse_rst();
      end else if (r <= 2) begin
        wait_cycles(int'($urandom_range(0, 9)));
        for (int k = 0; k < 4; k++) begin
          v2[k] = int'($urandom_range(0, 4)) - 2;
          h2[k] = int'($urandom_range(0, 4)) - 2;
        end
        do_start(int'($urandom_range(0, 19)), int'($urandom_range(0, 9)), v2, h2);
      end
      wait_cycles(12);
    end

    wait_cycles(2);
    chk("final_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
